// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the BTB-based branch predictor.
// Counter encodings, index/tag width derivation and saturating counter steps.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic int idxWidth(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Tag field starts right above the word-aligned index field.
    function automatic int tagLsb(input int entries);
        return idxWidth(entries) + 2;
    endfunction

    function automatic logic [1:0] ctrInc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] ctrDec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with one
// combinational read port and one synchronous write port.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    localparam int IDX     = idxWidth(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX-1:0]      rdIdx,
    output logic                rdValid,
    output logic [TAG_BITS-1:0] rdTag,
    output logic [XLEN-1:0]     rdTarget,
    output logic [1:0]          rdCtr,
    input  logic                wrEn,
    input  logic                wrTgtEn,
    input  logic [IDX-1:0]      wrIdx,
    input  logic [TAG_BITS-1:0] wrTag,
    input  logic [XLEN-1:0]     wrTarget,
    input  logic [1:0]          wrCtr
);

    logic [ENTRIES-1:0]  validQ;
    logic [1:0]          ctrQ    [ENTRIES];
    logic [TAG_BITS-1:0] tagQ    [ENTRIES];
    logic [XLEN-1:0]     targetQ [ENTRIES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= SNT;
        end else if (wrEn) begin
            validQ[wrIdx] <= 1'b1;
            ctrQ[wrIdx]   <= wrCtr;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagQ[wrIdx] <= wrTag;
            if (wrTgtEn) targetQ[wrIdx] <= wrTarget;
        end
    end

    assign rdValid  = validQ[rdIdx];
    assign rdTag    = tagQ[rdIdx];
    assign rdTarget = targetQ[rdIdx];
    assign rdCtr    = ctrQ[rdIdx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF-stage BTB lookup, one-deep prediction record,
// resolution compare with redirect, table training and statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter int         TAG_BITS = 8,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetchPc,
    input  logic            fetchValid,
    input  logic            stall,
    output logic            predTaken,
    output logic [XLEN-1:0] predTarget,
    input  logic            resValid,
    input  logic            resIsCond,
    input  logic            resIsJump,
    input  logic            resTaken,
    input  logic [XLEN-1:0] resTarget,
    output logic            mispredict,
    output logic [XLEN-1:0] redirectAddr,
    output logic [31:0]     statLookups,
    output logic [31:0]     statMispredicts
);

    localparam int IDX  = idxWidth(ENTRIES);
    localparam int TLSB = tagLsb(ENTRIES);

    function automatic logic [IDX-1:0] idxOf(input logic [XLEN-1:0] pc);
        return pc[IDX+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] tagOf(input logic [XLEN-1:0] pc);
        return pc[TLSB+TAG_BITS-1:TLSB];
    endfunction

    logic                rdValid, hit;
    logic [TAG_BITS-1:0] rdTag;
    logic [XLEN-1:0]     rdTarget;
    logic [1:0]          rdCtr;
    logic [IDX-1:0]      fetchIdx, wrIdx, srcIdx;
    logic [TAG_BITS-1:0] fetchTag, wrTag, srcTag;
    logic                wrEn, wrTgtEn;
    logic [1:0]          wrCtr;

    logic                recValid, recTaken, recHit;
    logic [XLEN-1:0]     recPc, recTarget;
    logic [1:0]          recCtr;
    logic                accepted, loadRec, srcHit, nextHit;
    logic [1:0]          srcCtr, nextCtr;

    assign fetchIdx = idxOf(fetchPc);
    assign fetchTag = tagOf(fetchPc);

    bp_table #(
        .XLEN     (XLEN),
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS)
    ) uTable (
        .clk      (clk),
        .reset    (reset),
        .rdIdx    (fetchIdx),
        .rdValid  (rdValid),
        .rdTag    (rdTag),
        .rdTarget (rdTarget),
        .rdCtr    (rdCtr),
        .wrEn     (wrEn),
        .wrTgtEn  (wrTgtEn),
        .wrIdx    (wrIdx),
        .wrTag    (wrTag),
        .wrTarget (resTarget),
        .wrCtr    (wrCtr)
    );

    // Fetch stage: combinational prediction
    assign hit        = rdValid & (rdTag == fetchTag);
    assign predTaken  = hit & rdCtr[1];
    assign predTarget = predTaken ? rdTarget : fetchPc + XLEN'(4);

    // Resolve stage: compare against the recorded prediction
    assign accepted     = resValid & recValid;
    assign mispredict   = accepted & ((recTaken != resTaken) |
                                      (resTaken & (recTarget != resTarget)));
    assign redirectAddr = !mispredict ? '0 :
                          resTaken    ? resTarget : recPc + XLEN'(4);

    assign wrIdx = idxOf(recPc);
    assign wrTag = tagOf(recPc);

    always_comb begin
        wrEn    = 1'b0;
        wrTgtEn = 1'b0;
        wrCtr   = recCtr;
        if (accepted) begin
            if (recHit) begin
                wrEn = 1'b1;
                if (resIsJump) begin
                    wrCtr   = ST;
                    wrTgtEn = 1'b1;
                end else if (resIsCond && resTaken) begin
                    wrCtr   = ctrInc(recCtr);
                    wrTgtEn = 1'b1;
                end else begin
                    wrCtr = ctrDec(recCtr);
                end
            end else if ((resIsCond || resIsJump) && resTaken) begin
                wrEn    = 1'b1;
                wrTgtEn = 1'b1;
                wrCtr   = resIsJump ? ST : CTR_INIT;
            end
        end
    end

    // The recorded hit/counter must reflect a table write landing on the same
    // edge, otherwise back-to-back branches sharing an index train from stale state.
    assign loadRec = fetchValid & ~stall & ~mispredict;
    assign srcIdx  = loadRec ? fetchIdx : wrIdx;
    assign srcTag  = loadRec ? fetchTag : wrTag;
    assign srcHit  = loadRec ? hit      : recHit;
    assign srcCtr  = loadRec ? rdCtr    : recCtr;
    assign nextHit = (wrEn && wrIdx == srcIdx) ? (wrTag == srcTag) : srcHit;
    assign nextCtr = (wrEn && wrIdx == srcIdx) ? wrCtr : srcCtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recValid        <= 1'b0;
            statLookups     <= '0;
            statMispredicts <= '0;
        end else begin
            if (mispredict) recValid <= 1'b0;
            else if (!stall) recValid <= fetchValid;
            if (loadRec) statLookups <= statLookups + 32'd1;
            if (mispredict) statMispredicts <= statMispredicts + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (loadRec) begin
            recPc     <= fetchPc;
            recTaken  <= predTaken;
            recTarget <= predTarget;
        end
        recHit <= nextHit;
        recCtr <= nextCtr;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage core. It predicts direction and target in IF from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It records each fetch-time prediction and checks it against the resolved outcome from the decode-stage branch unit one stage later. On a mismatch it raises a mispredict with the correct redirect address. It replaces the current "always not-taken, flush on taken" policy.

## Interface
Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, number of BTB entries; power of two, ≥2
- TAG_BITS, 8, tag width stored per entry
- CTR_INIT, 2'b10, counter value written when a taken branch allocates an entry

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fetchPc  in  XLEN  PC currently presented to the instruction ROM
- fetchValid  in  1  fetchPc holds a real fetch (not a reset/flush bubble)
- stall  in  1  PC/IF_ID locker asserted; hold the recorded prediction
- predTaken  out  1  predicted taken for fetchPc
- predTarget  out  XLEN  predicted next PC when predTaken, else fetchPc+4
- resValid  in  1  branch unit resolved a control-transfer instruction this cycle
- resIsCond  in  1  resolved instruction is a conditional branch
- resIsJump  in  1  resolved instruction is JAL/JALR
- resTaken  in  1  actual direction (forced 1 for jumps)
- resTarget  in  XLEN  actual taken target
- mispredict  out  1  recorded prediction wrong; PC must take redirectAddr, IF_ID flushes
- redirectAddr  out  XLEN  correct next PC
- statLookups  out  32  count of recorded predictions
- statMispredicts  out  32  count of mispredict pulses

## Operation
- Index = fetchPc[IDX+1:2], IDX = log2(ENTRIES); tag = next TAG_BITS bits above the index. Bits [1:0] are ignored.
- Lookup (combinational): hit = valid[idx] & tag match. predTaken = hit & ctr[1]. predTarget = predTaken ? target[idx] : fetchPc+4 (XLEN wrap).
- Record register {recValid, recPc, recTaken, recTarget}:
  - Loads lookup results when fetchValid & !stall & !mispredict.
  - Holds when stall.
  - Cleared (recValid=0) when mispredict or when !fetchValid & !stall.
  - statLookups increments on each load.
- Resolution is accepted only when resValid & recValid; otherwise resolution inputs are ignored.
- Mispredict = accepted & ((recTaken != resTaken) | (resTaken & recTarget != resTarget)).
- redirectAddr = resTaken ? resTarget : recPc+4. redirectAddr is 0 when mispredict is low.
- Table update on accepted & (resIsCond | resIsJump), at recPc's index/tag:
  - Hit, cond: counter saturating +1 if taken, -1 if not (00..11); target ← resTarget if taken.
  - Hit, jump: counter ← 11, target ← resTarget.
  - Miss, taken: allocate (overwrite); valid=1, tag, target; counter = jump ? 11 : CTR_INIT.
  - Miss, not taken: no allocation.
- A resolution with resIsCond=resIsJump=0 still evaluates mispredict, e.g. for an aliasing false hit. On a hit it decrements the counter toward not-taken; on a miss it does nothing.
- statMispredicts increments on each mispredict; both counters wrap at 2^32.

## Timing
- Prediction: zero latency, combinational from fetchPc.
- Mispredict/redirectAddr: combinational in the resolve cycle; the PC loads redirectAddr on that edge.
- Table writes land on the rising edge. A same-cycle lookup to the same index sees the pre-write contents.
- Simultaneous mispredict and new fetch: the wrong-path fetch is not recorded.
- Stall with resValid: resolution is still accepted; the record holds its value but recValid is cleared on mispredict.
- Reset (any time, mid-update included) sets all valid bits = 0, counters = 00, record cleared, stats = 0. Outputs after reset: predTaken=0, predTarget=fetchPc+4, mispredict=0, redirectAddr=0.

## Structure
- Shared package constants: counter encodings SNT=00, WNT=01, WT=10, ST=11; helper for index/tag width derivation.
- Sub-module `bp_table`: valid/tag/target/counter arrays with one combinational read port and one synchronous write port, plus async reset of valid and counters.
- The top holds the record register, compare, update logic and stats.

## Test plan
- Reset, fetch 0x00..0x1C sequentially, no resolutions → predTaken=0, predTarget=pc+4, statLookups=8, no mispredict.
- Cond branch at 0x10 resolves taken to 0x40 → mispredict=1, redirectAddr=0x40. Next fetch of 0x10 gives predTaken=1, predTarget=0x40 (ctr=10).
- Same branch resolves not-taken twice → first: mispredict, redirectAddr=0x14, ctr=01. Second: no mispredict, ctr=00, predTaken=0.
- JAL at 0x20 to 0x80 → allocates ctr=11. Later resolves taken to 0x84 → mispredict, redirectAddr=0x84, target updated.
- stall held 3 cycles with fetchPc changing → record unchanged, statLookups unchanged. Resolution after release compares against the pre-stall prediction.
- Aliasing: ENTRIES=16; PCs 0x10 and 0x50 (same index, different tag), 0x10 trained taken → 0x50 misses (predTaken=0). Reset asserted mid-cycle during an update → all outputs return to their reset values immediately.
